// File: rtl/i2s_adc_receiver.sv
// I2S master receiver for a stereo line-in ADC: generates MCLK/SCK/LRCK, deserialises SDOUT, publishes L/R pairs.
// Optional build macro I2S_RX_MONO_EN adds sample_mono, the average of the published left and right samples.
module i2s_adc_receiver #(
    parameter int DATA_W        = 16,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     audio_sdout,
    output logic                     audio_mclk,
    output logic                     audio_lrck,
    output logic                     audio_sck,
    output logic signed [DATA_W-1:0] sample_left,
    output logic signed [DATA_W-1:0] sample_right,
    output logic                     sample_valid,
    input  logic                     sample_ready,
`ifdef I2S_RX_MONO_EN
    output logic signed [DATA_W-1:0] sample_mono,
`endif
    output logic                     overrun
);

    localparam logic [4:0] DW5       = 5'(DATA_W);
    localparam logic [8:0] LEFT_END  = {1'b0, DW5, 3'd7};
    localparam logic [8:0] FRAME_END = {1'b1, DW5, 3'd7};
    localparam logic [3:0] WARM_TGT  = 4'(WARMUP_FRAMES);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [8:0]               div_cnt;
    logic                     sd_m;
    logic                     sd_s;
    logic [DATA_W-1:0]        shift_reg;
    logic [DATA_W-1:0]        shift_nxt;
    logic signed [DATA_W-1:0] left_hold;
    logic [0:0]               state;
    logic [3:0]               warm_cnt;
    logic [4:0]               slot;
    logic                     strobe;
    logic                     in_word;
    logic                     left_done;
    logic                     frame_evt;
    logic                     publish;

`ifdef I2S_RX_MONO_EN
    // Sum at DATA_W+1 bits, then halve; the result always fits back in DATA_W.
    function automatic logic signed [DATA_W-1:0] mono_avg(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return sum[DATA_W:1];
    endfunction
`endif

    assign slot      = div_cnt[7:3];
    assign strobe    = (div_cnt[2:0] == 3'd7);
    assign in_word   = (slot != 5'd0) && (slot <= DW5);
    assign shift_nxt = (strobe && in_word) ? {shift_reg[DATA_W-2:0], sd_s} : shift_reg;
    assign left_done = (div_cnt == LEFT_END);
    assign frame_evt = (div_cnt == FRAME_END);
    assign publish   = frame_evt && (state == ST_RUN);

    assign audio_mclk = div_cnt[1];
    assign audio_sck  = div_cnt[2];
    assign audio_lrck = div_cnt[8];

    // Clock divider and SDOUT synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= 9'd0;
            sd_m    <= 1'b0;
            sd_s    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 9'd1;
            sd_m    <= audio_sdout;
            sd_s    <= sd_m;
        end
    end

    // Deserialiser: one-bit-delayed I2S, MSB first in slot 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            left_hold <= '0;
        end else begin
            shift_reg <= shift_nxt;
            if (left_done) begin
                left_hold <= shift_nxt;
            end
        end
    end

    // Warmup sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_WARMUP;
            warm_cnt <= 4'd0;
        end else if (state == ST_WARMUP) begin
            if (warm_cnt == WARM_TGT) begin
                state <= ST_RUN;
            end else if (frame_evt) begin
                warm_cnt <= warm_cnt + 4'd1;
            end
        end
    end

    // Publish stage and valid/ready handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef I2S_RX_MONO_EN
            sample_mono  <= '0;
`endif
        end else if (publish) begin
            sample_left  <= left_hold;
            sample_right <= shift_nxt;
            sample_valid <= 1'b1;
`ifdef I2S_RX_MONO_EN
            sample_mono  <= mono_avg(left_hold, $signed(shift_nxt));
`endif
            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: a bench-side ADC model serialises known words; results compared per frame.
module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdout;
    logic        ready;
    logic        mclk;
    logic        lrck;
    logic        sck;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        s_valid;
    logic        ovr;
`ifdef I2S_RX_MONO_EN
    logic [15:0] s_mono;
`endif

    logic [8:0]  tb_cnt;
    logic [15:0] cur_l;
    logic [15:0] cur_r;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int   cnt;
        logic mclk;
        logic sck;
        logic lrck;
        logic valid;
    } div_vec_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        rdy;
        logic        valid;
        logic [15:0] el;
        logic [15:0] er;
        logic        ovr;
    } frame_vec_t;

    i2s_adc_receiver #(.DATA_W(16), .WARMUP_FRAMES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .audio_sdout  (sdout),
        .audio_mclk   (mclk),
        .audio_lrck   (lrck),
        .audio_sck    (sck),
        .sample_left  (s_left),
        .sample_right (s_right),
        .sample_valid (s_valid),
        .sample_ready (ready),
`ifdef I2S_RX_MONO_EN
        .sample_mono  (s_mono),
`endif
        .overrun      (ovr)
    );

    always #5 clk = ~clk;

    // Reference timebase: clk count since reset release, wraps every 512 clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tb_cnt <= 9'd0;
        else      tb_cnt <= tb_cnt + 9'd1;
    end

    // ADC model: word bit for slot k is driven from the start of slot k, MSB in slot 1
    initial begin
        int s;
        sdout = 1'b0;
        forever begin
            @(negedge clk);
            s = int'(tb_cnt[7:3]);
            if (s >= 1 && s <= 16) sdout = tb_cnt[8] ? cur_r[16-s] : cur_l[16-s];
            else                   sdout = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cnt(input int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_cnt != 9'(t) && n < 1200);
        if (tb_cnt != 9'(t)) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt_%0d: timed out at cnt %0d", t, tb_cnt);
        end
    endtask

    task automatic run_frame(input frame_vec_t v, input int idx);
        wait_cnt(0);
        cur_l = v.l;
        cur_r = v.r;
        ready = v.rdy;
        wait_cnt(392);
        check($sformatf("frame%0d_valid", idx), 16'(s_valid), 16'(v.valid));
        check($sformatf("frame%0d_left", idx), s_left, v.el);
        check($sformatf("frame%0d_right", idx), s_right, v.er);
        check($sformatf("frame%0d_overrun", idx), 16'(ovr), 16'(v.ovr));
        if (v.rdy && v.valid) begin
            @(negedge clk);
            check($sformatf("frame%0d_valid_drop", idx), 16'(s_valid), 16'd0);
        end
    endtask

    initial begin
        div_vec_t   dv[9];
        frame_vec_t fv[6];

        dv[0] = '{2,   1'b1, 1'b0, 1'b0, 1'b0};
        dv[1] = '{4,   1'b0, 1'b1, 1'b0, 1'b0};
        dv[2] = '{6,   1'b1, 1'b1, 1'b0, 1'b0};
        dv[3] = '{8,   1'b0, 1'b0, 1'b0, 1'b0};
        dv[4] = '{255, 1'b1, 1'b1, 1'b0, 1'b0};
        dv[5] = '{256, 1'b0, 1'b0, 1'b1, 1'b0};
        dv[6] = '{260, 1'b0, 1'b1, 1'b1, 1'b0};
        dv[7] = '{392, 1'b0, 1'b0, 1'b1, 1'b0};
        dv[8] = '{511, 1'b1, 1'b1, 1'b1, 1'b0};

        fv[0] = '{16'h8001, 16'h7FFE, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        fv[1] = '{16'h8001, 16'h7FFE, 1'b1, 1'b1, 16'h8001, 16'h7FFE, 1'b0};
        fv[2] = '{16'h1234, 16'hFEDC, 1'b1, 1'b1, 16'h1234, 16'hFEDC, 1'b0};
        fv[3] = '{16'h1111, 16'h2222, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0};
        fv[4] = '{16'h3333, 16'h4444, 1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1};
        fv[5] = '{16'h5555, 16'h6666, 1'b1, 1'b1, 16'h5555, 16'h6666, 1'b1};

        rst   = 1'b0;
        ready = 1'b1;
        cur_l = 16'h8001;
        cur_r = 16'h7FFE;
        repeat (10) @(negedge clk);
        check("rst_valid", 16'(s_valid), 16'd0);
        check("rst_left", s_left, 16'h0000);
        check("rst_right", s_right, 16'h0000);
        check("rst_overrun", 16'(ovr), 16'd0);
        check("rst_clocks", {13'd0, mclk, sck, lrck}, 16'd0);
        rst = 1'b1;

        // Frame 0 after reset: divider waveform and first warmup frame
        for (int i = 0; i < 9; i++) begin
            wait_cnt(dv[i].cnt);
            check($sformatf("div%0d_mclk", dv[i].cnt), 16'(mclk), 16'(dv[i].mclk));
            check($sformatf("div%0d_sck", dv[i].cnt), 16'(sck), 16'(dv[i].sck));
            check($sformatf("div%0d_lrck", dv[i].cnt), 16'(lrck), 16'(dv[i].lrck));
            check($sformatf("div%0d_valid", dv[i].cnt), 16'(s_valid), 16'(dv[i].valid));
        end

        for (int i = 0; i < 3; i++) run_frame(fv[i], i);

        // Ready rises exactly in the frame-event cycle while an older pair is pending
        wait_cnt(0);
        cur_l = 16'h0F0F;
        cur_r = 16'hF0F0;
        ready = 1'b0;
        wait_cnt(392);
        check("pend_valid", 16'(s_valid), 16'd1);
        check("pend_left", s_left, 16'h0F0F);
        check("pend_right", s_right, 16'hF0F0);
        wait_cnt(0);
        cur_l = 16'hAAAA;
        cur_r = 16'h5555;
        wait_cnt(391);
        check("pend_hold_valid", 16'(s_valid), 16'd1);
        check("pend_hold_left", s_left, 16'h0F0F);
        ready = 1'b1;
        wait_cnt(392);
        check("simul_valid", 16'(s_valid), 16'd1);
        check("simul_left", s_left, 16'hAAAA);
        check("simul_right", s_right, 16'h5555);
        check("simul_overrun", 16'(ovr), 16'd0);
        @(negedge clk);
        check("simul_valid_drop", 16'(s_valid), 16'd0);

        for (int i = 3; i < 6; i++) run_frame(fv[i], i);

`ifdef I2S_RX_MONO_EN
        wait_cnt(0);
        cur_l = 16'h7FFF;
        cur_r = 16'h7FFF;
        ready = 1'b1;
        wait_cnt(392);
        check("mono_pos", s_mono, 16'h7FFF);
        wait_cnt(0);
        cur_l = 16'h8000;
        cur_r = 16'h8000;
        wait_cnt(392);
        check("mono_neg", s_mono, 16'h8000);
`endif

        // Asynchronous reset in mid-frame, then warmup restarts
        wait_cnt(0);
        cur_l = 16'h4321;
        cur_r = 16'hABCD;
        ready = 1'b1;
        wait_cnt(200);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 16'(s_valid), 16'd0);
        check("mid_rst_left", s_left, 16'h0000);
        check("mid_rst_right", s_right, 16'h0000);
        check("mid_rst_overrun", 16'(ovr), 16'd0);
        check("mid_rst_clocks", {13'd0, mclk, sck, lrck}, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_cnt(392);
        check("rewarm0_valid", 16'(s_valid), 16'd0);
        wait_cnt(392);
        check("rewarm1_valid", 16'(s_valid), 16'd0);
        wait_cnt(392);
        check("rewarm2_valid", 16'(s_valid), 16'd1);
        check("rewarm2_left", s_left, 16'h4321);
        check("rewarm2_right", s_right, 16'hABCD);
        check("rewarm2_overrun", 16'(ovr), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
